// File: rtl/maxnet_pkg.sv
// Shared constants and types for the 4-neuron Maxnet iterator.
// Activations are unsigned Q16.16; EPS is Q0.16.
package maxnet_pkg;
  localparam int W    = 32;
  localparam int FRAC = 16;

  typedef logic [W-1:0] act_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/maxnet_lane.sv
// One lateral-inhibition lane: next_x = relu(x - (EPS * (S - x)) >> FRAC).
// Purely combinational; the top instantiates four of these.
module maxnet_lane
  import maxnet_pkg::*;
#(
  parameter int EPS = 16384
) (
  input  logic [W-1:0] i_x,
  input  logic [W+1:0] i_sum,
  output logic [W-1:0] o_nxt
);
  localparam int PW = W + 18;

  logic [W+1:0]  w_rest;
  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_shift;
  logic [PW-1:0] w_diff;

  assign w_rest  = i_sum - (W+2)'(i_x);
  assign w_prod  = PW'(w_rest) * PW'(EPS);
  assign w_shift = w_prod >> FRAC;
  assign w_diff  = PW'(i_x) - w_shift;

  // Clamp at zero instead of wrapping when inhibition exceeds the activation
  always_comb begin
    o_nxt = '0;
    if (w_shift >= PW'(i_x)) begin
      o_nxt = '0;
    end else begin
      o_nxt = W'(w_diff);
    end
  end
endmodule

// File: rtl/maxnet_iterator.sv
// Sequential Maxnet stage: loads four activations and applies one inhibition
// update per clock until the terminator reports done, all lanes die, or the budget ends.
module maxnet_iterator
  import maxnet_pkg::*;
#(
  parameter int EPS      = 16384,
  parameter int MAX_ITER = 255,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  in_x1,
  input  logic [W-1:0]  in_x2,
  input  logic [W-1:0]  in_x3,
  input  logic [W-1:0]  in_x4,
  input  logic          term_done,
  output logic [W-1:0]  x1,
  output logic [W-1:0]  x2,
  output logic [W-1:0]  x3,
  output logic [W-1:0]  x4,
  output logic          o1,
  output logic          o2,
  output logic          o3,
  output logic          o4,
  output logic          busy,
  output logic          valid,
  output logic          timeout,
  output logic          fail,
  output logic [CW-1:0] iter_count
);
  state_t        r_state;
  logic [W-1:0]  r_x1, r_x2, r_x3, r_x4;
  logic          r_busy, r_valid, r_timeout, r_fail;
  logic [CW-1:0] r_iter;

  logic [W+1:0]  w_sum;
  logic [W-1:0]  w_nxt1, w_nxt2, w_nxt3, w_nxt4;
  logic          w_none;

  // Sum is widened by two bits so four full-scale activations cannot overflow
  assign w_sum  = (W+2)'(r_x1) + (W+2)'(r_x2) + (W+2)'(r_x3) + (W+2)'(r_x4);
  assign w_none = ~(o1 | o2 | o3 | o4);

  maxnet_lane #(.EPS(EPS)) u_lane1 (.i_x(r_x1), .i_sum(w_sum), .o_nxt(w_nxt1));
  maxnet_lane #(.EPS(EPS)) u_lane2 (.i_x(r_x2), .i_sum(w_sum), .o_nxt(w_nxt2));
  maxnet_lane #(.EPS(EPS)) u_lane3 (.i_x(r_x3), .i_sum(w_sum), .o_nxt(w_nxt3));
  maxnet_lane #(.EPS(EPS)) u_lane4 (.i_x(r_x4), .i_sum(w_sum), .o_nxt(w_nxt4));

  // Control FSM, activation registers and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_x1      <= '0;
      r_x2      <= '0;
      r_x3      <= '0;
      r_x4      <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_fail    <= 1'b0;
      r_iter    <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state   <= ITER;
            r_x1      <= in_x1;
            r_x2      <= in_x2;
            r_x3      <= in_x3;
            r_x4      <= in_x4;
            r_busy    <= 1'b1;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_fail    <= 1'b0;
            r_iter    <= '0;
          end
        end
        ITER: begin
          if (term_done) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
          end else if (w_none) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_fail  <= 1'b1;
          end else if (r_iter == CW'(MAX_ITER)) begin
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_valid   <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_x1   <= w_nxt1;
            r_x2   <= w_nxt2;
            r_x3   <= w_nxt3;
            r_x4   <= w_nxt4;
            r_iter <= r_iter + CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign x1         = r_x1;
  assign x2         = r_x2;
  assign x3         = r_x3;
  assign x4         = r_x4;
  assign o1         = (r_x1 != '0);
  assign o2         = (r_x2 != '0);
  assign o3         = (r_x3 != '0);
  assign o4         = (r_x4 != '0);
  assign busy       = r_busy;
  assign valid      = r_valid;
  assign timeout    = r_timeout;
  assign fail       = r_fail;
  assign iter_count = r_iter;
endmodule
